// File: rtl/uart_hex_reporter.sv
// Snapshots a DATA_W-bit word and sends it to uart_tx as the ASCII frame TAG ':' <hex digits> CR LF.
// Optional build macro UART_REPORT_SEQ_EN adds an 8-bit frame sequence number (two hex digits) after TAG.
module uart_hex_reporter #(
    parameter int          DATA_W     = 32,
    parameter int          PERIOD_CYC = 2700000,
    parameter logic [7:0]  TAG        = 8'h44
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              trig,
    input  logic              auto_en,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        drop_cnt
);

    localparam int NDIG = DATA_W / 4;
`ifdef UART_REPORT_SEQ_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 2;
`endif
    localparam int NBYTES = NDIG + HDR + 2;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int TMR_W  = $clog2(PERIOD_CYC);

    localparam logic [IDX_W-1:0] IDX_COLON = IDX_W'(HDR - 1);
    localparam logic [IDX_W-1:0] IDX_CR    = IDX_W'(NBYTES - 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NBYTES - 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(PERIOD_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

    logic [1:0]        state_q,      state_d;
    logic [IDX_W-1:0]  idx_q,        idx_d;
    logic [TMR_W-1:0]  timer_q,      timer_d;
    logic [DATA_W-1:0] snap_q,       snap_d;
    logic              tx_en_q,      tx_en_d;
    logic [7:0]        tx_data_q,    tx_data_d;
    logic              busy_q,       busy_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        drop_q,       drop_d;
`ifdef UART_REPORT_SEQ_EN
    logic [7:0]        seq_q,        seq_d;
`endif

    logic [IDX_W-1:0]  digit_s;
    logic [DATA_W-1:0] snap_shift_s;
    logic [7:0]        byte_s;
    logic              start_s;

    // Byte for the current frame index; digits are shifted so the wanted nibble sits at the top.
    always_comb begin
        digit_s      = idx_q - IDX_W'(HDR);
        snap_shift_s = snap_q << {digit_s, 2'b00};
        byte_s       = 8'h00;
        if (idx_q == {IDX_W{1'b0}}) begin
            byte_s = TAG;
`ifdef UART_REPORT_SEQ_EN
        end else if (idx_q == IDX_W'(1)) begin
            byte_s = hex_ascii(seq_q[7:4]);
        end else if (idx_q == IDX_W'(2)) begin
            byte_s = hex_ascii(seq_q[3:0]);
`endif
        end else if (idx_q == IDX_COLON) begin
            byte_s = 8'h3A;
        end else if (idx_q == IDX_CR) begin
            byte_s = 8'h0D;
        end else if (idx_q == IDX_LAST) begin
            byte_s = 8'h0A;
        end else begin
            byte_s = hex_ascii(snap_shift_s[DATA_W-1 -: 4]);
        end
    end

    // Frame sequencer, idle timer and trigger-overrun counter next-state logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        snap_d       = snap_q;
        tx_en_d      = 1'b0;
        tx_data_d    = tx_data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        drop_d       = drop_q;
`ifdef UART_REPORT_SEQ_EN
        seq_d        = seq_q;
`endif
        start_s      = trig || (auto_en && (timer_q == {TMR_W{1'b0}}));

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    snap_d  = data_in;
                    idx_d   = {IDX_W{1'b0}};
                    busy_d  = 1'b1;
                    timer_d = TMR_RELOAD;
                    state_d = ST_ISSUE;
                end else if (auto_en) begin
                    timer_d = timer_q - TMR_W'(1);
                end else begin
                    timer_d = TMR_RELOAD;
                end
            end
            ST_ISSUE: begin
                if (!tx_busy) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = byte_s;
                    state_d   = ST_GUARD;
                end else begin
                    state_d   = ST_ISSUE;
                end
            end
            // uart_tx raises busy one cycle after the strobe, so this cycle ignores it.
            ST_GUARD: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (tx_busy) begin
                    state_d = ST_DRAIN;
                end else if (idx_q == IDX_LAST) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
`ifdef UART_REPORT_SEQ_EN
                    seq_d        = seq_q + 8'd1;
`endif
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (trig && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= {IDX_W{1'b0}};
            timer_q      <= TMR_RELOAD;
            snap_q       <= {DATA_W{1'b0}};
            tx_en_q      <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= 8'h00;
`ifdef UART_REPORT_SEQ_EN
            seq_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            snap_q       <= snap_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            drop_q       <= drop_d;
`ifdef UART_REPORT_SEQ_EN
            seq_q        <= seq_d;
`endif
        end
    end

    assign tx_en      = tx_en_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Self-checking bench for uart_hex_reporter: uart_tx model, frame capture and a byte-list reference model.
module tb_uart_hex_reporter;

    localparam int DATA_W = 32;
    localparam int PERIOD = 100;
    localparam int NDIG   = DATA_W / 4;
`ifdef UART_REPORT_SEQ_EN
    localparam int NB = NDIG + 6;
`else
    localparam int NB = NDIG + 4;
`endif

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              trig = 1'b0;
    logic              auto_en = 1'b0;
    logic              tx_busy = 1'b0;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              busy;
    logic              frame_done;
    logic [7:0]        drop_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rel_cyc = 0;
    int   busy_len = 10;
    int   busy_cnt = 0;
    int   last_tx = -100;
    int   fd_cnt = 0;
    int   drops = 0;
    logic [7:0] exp_seq = 8'h00;
    bq_t  cap_q;
    bq_t  exp_q;

    uart_hex_reporter #(.DATA_W(DATA_W), .PERIOD_CYC(PERIOD), .TAG(8'h44)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .data_in(data_in), .trig(trig), .auto_en(auto_en),
        .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy),
        .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model: busy for busy_len cycles after each strobe; also captures bytes and frame_done pulses.
    always @(negedge clk) begin
        if (!rst_n) busy_cnt = 0;
        if (tx_en) begin
            cap_q.push_back(tx_data);
            checks++;
            if (cyc - last_tx < 3) begin
                errors++;
                $display("FAIL tx_spacing: got strobes %0d cycles apart, want >= 3", cyc - last_tx);
            end
            last_tx  = cyc;
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = (busy_cnt != 0);
        if (frame_done) fd_cnt++;
    end

    function automatic logic [7:0] asc(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    function automatic logic [127:0] pack(input bq_t q);
        logic [127:0] v = '0;
        foreach (q[i]) v = {v[119:0], q[i]};
        return v;
    endfunction

    task automatic build_exp(input logic [DATA_W-1:0] d);
        exp_q.delete();
        exp_q.push_back(8'h44);
`ifdef UART_REPORT_SEQ_EN
        exp_q.push_back(asc(int'(exp_seq) / 16));
        exp_q.push_back(asc(int'(exp_seq) % 16));
`endif
        exp_q.push_back(8'h3A);
        for (int i = NDIG - 1; i >= 0; i--) exp_q.push_back(asc(int'((d >> (4 * i)) & 32'hF)));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        trig  = 1'b0;
        repeat (3) tick();
        rst_n   = 1'b1;
        rel_cyc = cyc;
        exp_seq = 8'h00;
        drops   = 0;
        cap_q.delete();
        fd_cnt  = 0;
    endtask

    task automatic start_frame(input logic [DATA_W-1:0] d, output int sc);
        data_in = d;
        cap_q.delete();
        fd_cnt = 0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        sc = cyc;
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        dc = -1;
        while (n < 3000) begin
            tick();
            n++;
            if (frame_done) begin
                dc = cyc;
                exp_seq++;
                break;
            end
        end
        checks++;
        if (dc < 0) begin
            errors++;
            $display("FAIL frame_done_timeout: got no pulse in %0d cycles, want one", n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tx_en, tx_data, busy, frame_done, drop_cnt} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b data=%h busy=%b done=%b drop=%0d, want all 0",
                     tx_en, tx_data, busy, frame_done, drop_cnt);
        end
    endtask

    task automatic test_deadbeef();
        int sc, dc;
        busy_len = 10;
        build_exp(32'hDEADBEEF);
        start_frame(32'hDEADBEEF, sc);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL deadbeef_busy: got %b, want 1", busy); end
        wait_done(dc);
        checks++;
        if (cap_q.size() != NB || pack(cap_q) !== pack(exp_q)) begin
            errors++;
            $display("FAIL deadbeef_frame: got %0d bytes %h, want %0d bytes %h", cap_q.size(), pack(cap_q), NB, pack(exp_q));
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL deadbeef_busy_end: got %b, want 0", busy); end
        tick();
        checks++;
        if (frame_done !== 1'b0 || fd_cnt != 1) begin
            errors++;
            $display("FAIL deadbeef_done_pulse: got done=%b count=%0d, want 0 and 1", frame_done, fd_cnt);
        end
    endtask

    task automatic test_digits();
        logic [DATA_W-1:0] pats [2] = '{32'h01234567, 32'h89ABCDEF};
        int sc, dc;
        busy_len = 3;
        foreach (pats[k]) begin
            build_exp(pats[k]);
            start_frame(pats[k], sc);
            wait_done(dc);
            checks++;
            if (cap_q.size() != NB || pack(cap_q) !== pack(exp_q)) begin
                errors++;
                $display("FAIL digits_%0d: got %0d bytes %h, want %0d bytes %h", k, cap_q.size(), pack(cap_q), NB, pack(exp_q));
            end
        end
    endtask

    task automatic test_back_to_back();
        int sc, dc;
        logic [DATA_W-1:0] d;
        for (int k = 0; k < 6; k++) begin
            busy_len = (k == 0) ? 0 : $urandom_range(0, 12);
            d = $urandom;
            build_exp(d);
            start_frame(d, sc);
            wait_done(dc);
            checks++;
            if (cap_q.size() != NB || pack(cap_q) !== pack(exp_q)) begin
                errors++;
                $display("FAIL random_frame_%0d: got %0d bytes %h, want %0d bytes %h", k, cap_q.size(), pack(cap_q), NB, pack(exp_q));
            end
            if (busy_len == 0) begin
                checks++;
                if (dc - sc != 3 * NB) begin
                    errors++;
                    $display("FAIL min_frame_time: got %0d cycles, want %0d", dc - sc, 3 * NB);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int sc, dc;
        do_reset();
        busy_len = 10;
        build_exp(32'hCAFEF00D);
        start_frame(32'hCAFEF00D, sc);
        for (int k = 0; k < 3; k++) begin
            repeat (3) tick();
            trig = 1'b1;
            tick();
            trig = 1'b0;
            drops++;
        end
        wait_done(dc);
        repeat (60) tick();
        checks++;
        if (drop_cnt !== 8'(drops)) begin errors++; $display("FAIL overrun_drops: got %0d, want %0d", drop_cnt, drops); end
        checks++;
        if (fd_cnt != 1 || cap_q.size() != NB || pack(cap_q) !== pack(exp_q)) begin
            errors++;
            $display("FAIL overrun_frames: got %0d frames %0d bytes, want 1 frame %0d bytes", fd_cnt, cap_q.size(), NB);
        end
    endtask

    task automatic test_saturate();
        int sc, dc;
        busy_len = 40;
        build_exp(32'h0000FFFF);
        start_frame(32'h0000FFFF, sc);
        trig = 1'b1;
        repeat (300) tick();
        trig = 1'b0;
        drops = (drops + 300 > 255) ? 255 : drops + 300;
        wait_done(dc);
        repeat (20) tick();
        checks++;
        if (drop_cnt !== 8'(drops)) begin errors++; $display("FAIL saturate_drops: got %0d, want %0d", drop_cnt, drops); end
        checks++;
        if (fd_cnt != 1 || pack(cap_q) !== pack(exp_q)) begin
            errors++;
            $display("FAIL saturate_frame: got %0d frames %h, want 1 frame %h", fd_cnt, pack(cap_q), pack(exp_q));
        end
    endtask

    task automatic test_midframe_data();
        int sc, dc, n;
        logic [DATA_W-1:0] d;
        busy_len = 5;
        d = $urandom;
        build_exp(d);
        start_frame(d, sc);
        n = 0;
        while (cap_q.size() < 3 && n < 500) begin tick(); n++; end
        data_in = ~d;
        wait_done(dc);
        checks++;
        if (pack(cap_q) !== pack(exp_q)) begin
            errors++;
            $display("FAIL midframe_data: got %h, want %h", pack(cap_q), pack(exp_q));
        end
    endtask

    task automatic test_midframe_reset();
        int sc, n;
        busy_len = 5;
        start_frame($urandom, sc);
        n = 0;
        while (cap_q.size() < 6 && n < 500) begin tick(); n++; end
        checks++;
        if (tx_en !== 1'b1) begin errors++; $display("FAIL reset_setup: got tx_en=%b at byte 6, want 1", tx_en); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_en, tx_data, busy, frame_done, drop_cnt} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got en=%b data=%h busy=%b done=%b drop=%0d, want all 0",
                     tx_en, tx_data, busy, frame_done, drop_cnt);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        exp_seq = 8'h00;
        drops = 0;
        cap_q.delete();
        repeat (50) tick();
        checks++;
        if (fd_cnt != 0 || cap_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: got done=%0d bytes=%0d busy=%b, want 0 0 0", fd_cnt, cap_q.size(), busy);
        end
    endtask

    task automatic test_periodic();
        int sc, dc, n;
        logic [DATA_W-1:0] d;
        d = $urandom;
        data_in = d;
        busy_len = 2;
        auto_en = 1'b1;
        do_reset();
        dc = rel_cyc;
        for (int k = 0; k < 3; k++) begin
            build_exp(d);
            n = 0;
            while (!busy && n < 400) begin tick(); n++; end
            sc = cyc;
            cap_q.delete();
            checks++;
            if (sc - dc != PERIOD) begin
                errors++;
                $display("FAIL periodic_start_%0d: got %0d cycles, want %0d", k, sc - dc, PERIOD);
            end
            wait_done(dc);
            checks++;
            if (pack(cap_q) !== pack(exp_q)) begin
                errors++;
                $display("FAIL periodic_frame_%0d: got %h, want %h", k, pack(cap_q), pack(exp_q));
            end
        end
        auto_en = 1'b0;
        cap_q.delete();
        repeat (300) tick();
        checks++;
        if (cap_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL periodic_off: got %0d bytes busy=%b, want 0 and 0", cap_q.size(), busy);
        end
    endtask

`ifdef UART_REPORT_SEQ_EN
    task automatic test_seq();
        int sc, dc;
        logic [DATA_W-1:0] d;
        do_reset();
        busy_len = 0;
        for (int k = 0; k < 258; k++) begin
            d = $urandom;
            build_exp(d);
            start_frame(d, sc);
            wait_done(dc);
            checks++;
            if (cap_q.size() != NB || pack(cap_q) !== pack(exp_q)) begin
                errors++;
                $display("FAIL seq_frame_%0d: got %0d bytes %h, want %0d bytes %h", k, cap_q.size(), pack(cap_q), NB, pack(exp_q));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_deadbeef();
        test_digits();
        test_back_to_back();
        test_overrun();
        test_saturate();
        test_midframe_data();
        test_midframe_reset();
        test_periodic();
`ifdef UART_REPORT_SEQ_EN
        test_seq();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
